// File: rtl/shiftadd_mul_ctrl_pkg.sv
// Shared definitions for the shift-and-add multiplier controller:
// state encodings and the iteration-counter width helper.
package shiftadd_mul_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Counter must be able to represent 0..nbits.
    function automatic int cnt_width(input int nbits);
        return $clog2(nbits + 1);
    endfunction

endpackage

// File: rtl/addergen_st.sv
// Parameterised ripple-carry adder built from a chain of full-adder cells.
module addergen_st #(
    parameter int NBITS = 16
) (
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic             cin,
    output logic [NBITS-1:0] sum,
    output logic             cout
);

    logic [NBITS:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < NBITS; i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[NBITS];

endmodule

// File: rtl/shiftadd_mul_ctrl.sv
// Sequential unsigned multiplier: one add-and-shift per cycle for NBITS cycles,
// fixed latency, single ripple adder on the datapath.
module shiftadd_mul_ctrl
    import shiftadd_mul_ctrl_pkg::*;
#(
    parameter int NBITS = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [NBITS-1:0]   a,
    input  logic [NBITS-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*NBITS-1:0] p
);

    localparam int CNT_W = cnt_width(NBITS);

    state_t           state, next_state;
    logic [NBITS-1:0] mcand;
    logic [NBITS-1:0] acc_hi;
    logic [NBITS-1:0] acc_lo;
    logic [CNT_W-1:0] cnt;
    logic [NBITS-1:0] add_b;
    logic [NBITS-1:0] sum;
    logic             cout;
    logic             last_iter;
    logic [2*NBITS-1:0] shifted;

    assign add_b     = acc_lo[0] ? mcand : '0;
    assign last_iter = (cnt == CNT_W'(NBITS - 1));
    // Carry is kept as the new MSB so the full 2*NBITS product never overflows.
    assign shifted   = {cout, sum, acc_lo[NBITS-1:1]};

    addergen_st #(.NBITS(NBITS)) u_add (
        .a    (acc_hi),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = ST_IDLE;
        case (state)
            ST_IDLE: next_state = start ? ST_CALC : ST_IDLE;
            ST_CALC: next_state = last_iter ? ST_DONE : ST_CALC;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            p      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand  <= a;
                        acc_hi <= '0;
                        acc_lo <= b;
                        cnt    <= '0;
                    end
                end
                ST_CALC: begin
                    {acc_hi, acc_lo} <= shifted;
                    cnt              <= cnt + 1'b1;
                    if (last_iter) p <= shifted;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state == ST_CALC);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_shiftadd_mul_ctrl.sv
// Directed bench for shiftadd_mul_ctrl (NBITS=16): vector table plus
// hand-written sequences for restart, mid-operation reset and back-to-back.
module tb_shiftadd_mul_ctrl;

    localparam int NBITS = 16;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [NBITS-1:0]   a;
    logic [NBITS-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*NBITS-1:0] p;

    int n_checks = 0;
    int n_fail   = 0;
    logic [2*NBITS-1:0] last_p = '0;

    typedef struct {
        logic [NBITS-1:0]   va;
        logic [NBITS-1:0]   vb;
        logic [2*NBITS-1:0] exp;
        bit                 restart;
    } vec_t;

    vec_t vecs [8];

    shiftadd_mul_ctrl #(.NBITS(NBITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full operation with cycle-exact checks of busy/done/p.
    task automatic do_mul(input logic [NBITS-1:0] va, input logic [NBITS-1:0] vb,
                          input logic [2*NBITS-1:0] exp, input bit restart, input string tag);
        bit calc_ok;
        bit hold_ok;
        @(negedge clk);
        a = va; b = vb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = NBITS'($urandom); b = NBITS'($urandom);
        chk({tag, " busy after accept"}, 64'(busy), 64'd1);
        calc_ok = 1'b1;
        hold_ok = 1'b1;
        for (int i = 1; i < NBITS; i++) begin
            if (restart && i == 5) begin
                @(negedge clk);
                start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
            end else if (restart && i == 6) begin
                @(negedge clk);
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (busy !== 1'b1 || done !== 1'b0) calc_ok = 1'b0;
            if (p !== last_p) hold_ok = 1'b0;
        end
        chk({tag, " busy/done during calc"}, 64'(calc_ok), 64'd1);
        chk({tag, " p held during calc"}, 64'(hold_ok), 64'd1);
        @(posedge clk); #1;
        chk({tag, " done pulse"}, 64'({busy, done}), 64'b01);
        chk({tag, " product"}, 64'(p), 64'(exp));
        last_p = exp;
        @(posedge clk); #1;
        chk({tag, " done one cycle"}, 64'({busy, done}), 64'b00);
        @(posedge clk); #1;
        chk({tag, " no extra op"}, 64'({busy, done}), 64'b00);
    endtask

    initial begin
        vecs[0] = '{16'd3,    16'd5,    32'h0000000F, 1'b0};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0};
        vecs[2] = '{16'h8000, 16'h0002, 32'h00010000, 1'b0};
        vecs[3] = '{16'h0000, 16'h1234, 32'h00000000, 1'b0};
        vecs[4] = '{16'h1234, 16'h0000, 32'h00000000, 1'b0};
        vecs[5] = '{16'h00FF, 16'h0101, 32'h0000FFFF, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 32'h40000000, 1'b0};
        vecs[7] = '{16'd11,   16'd13,   32'h0000008F, 1'b1};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        #2;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset p", 64'(p), 64'd0);
        // start high during reset must not be accepted
        start = 1'b1; a = 16'd9; b = 16'd9;
        repeat (2) @(posedge clk);
        #1;
        chk("start ignored in reset", 64'({busy, done}), 64'b00);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++)
            do_mul(vecs[k].va, vecs[k].vb, vecs[k].exp, vecs[k].restart, $sformatf("vec%0d", k));

        // Reset in the 8th CALC cycle aborts with no done and p cleared.
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("busy before abort", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort p", 64'(p), 64'd0);
        last_p = '0;
        @(negedge clk);
        rst_n = 1'b1;
        begin
            bit quiet = 1'b1;
            repeat (20) begin
                @(posedge clk); #1;
                if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
            end
            chk("no done after abort", 64'(quiet), 64'd1);
        end
        do_mul(16'd7, 16'd9, 32'h0000003F, 1'b0, "post-reset");

        // Back-to-back with start held: done every 18 cycles, p=6.
        begin
            int cyc = 0;
            int ndone = 0;
            int done_at [3];
            @(negedge clk);
            a = 16'd2; b = 16'd3; start = 1'b1;
            @(posedge clk); #1;
            while (ndone < 3 && cyc < 70) begin
                @(posedge clk); #1;
                cyc++;
                if (done === 1'b1) begin
                    done_at[ndone] = cyc;
                    chk($sformatf("b2b p %0d", ndone), 64'(p), 64'd6);
                    ndone++;
                end
            end
            start = 1'b0;
            chk("b2b done count", 64'(ndone), 64'd3);
            if (ndone == 3) begin
                chk("b2b first done", 64'(done_at[0]), 64'd16);
                chk("b2b period 1", 64'(done_at[1] - done_at[0]), 64'd18);
                chk("b2b period 2", 64'(done_at[2] - done_at[1]), 64'd18);
            end
            repeat (3) @(posedge clk);
            #1;
            chk("b2b drained", 64'({busy, done}), 64'b00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shiftadd_mul_ctrl.md
SHIFTADD_MUL_CTRL -- requirements
Module: shiftadd_mul_ctrl

Interface
REQ-001 Parameter NBITS, default 16: operand width; legal range 2..32.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to multiply a by b; sampled only in IDLE.
REQ-005 a  input  NBITS  multiplicand, unsigned; captured on the accepted start.
REQ-006 b  input  NBITS  multiplier, unsigned; captured on the accepted start.
REQ-007 busy  output  1  high while in CALC.
REQ-008 done  output  1  one-cycle pulse; p is valid and new in this cycle.
REQ-009 p  output  2*NBITS  unsigned product; holds the last result until the next completion.

Function
REQ-010 The FSM SHALL have three states:
- IDLE: start=1 -> CALC; else stay.
- CALC: after the NBITS-th iteration -> DONE; else stay.
- DONE: unconditional -> IDLE.
REQ-011 On the edge that accepts start, the block SHALL load:
- mcand <= a
- acc_hi <= 0
- acc_lo <= b
- iteration counter <= 0
REQ-012 Each CALC edge SHALL perform one iteration:
- Adder input: acc_hi + (acc_lo[0] ? mcand : 0), cin = 0.
- {acc_hi, acc_lo} <= {cout, sum, acc_lo[NBITS-1:1]}, a right shift that retains the adder carry.
- Counter increments by 1.
REQ-013 On the edge leaving CALC, p SHALL load {acc_hi, acc_lo} as produced by that final iteration.
REQ-014 Latency SHALL be fixed:
- start accepted at edge T.
- busy high from T to T+NBITS.
- done high from T+NBITS to T+NBITS+1, independent of operand values.
REQ-015 start SHALL be ignored in CALC and DONE; there are no queued requests. The earliest next accept is the edge after DONE (back-to-back throughput is one product per NBITS+2 cycles while start is held high).
REQ-016 Changes on a and b after acceptance SHALL NOT affect the running product.
REQ-017 The product SHALL be exact modulo 2^(2*NBITS); no overflow is possible. Maximum case: (2^NBITS-1)^2.
REQ-018 busy and done SHALL be registered (decoded from the state register), never combinational from start.

Reset
REQ-019 When rst_n=0, the block SHALL asynchronously force:
- state = IDLE
- busy = 0, done = 0, p = 0
- mcand, acc_hi, acc_lo and counter = 0
REQ-020 Reset asserted mid-CALC SHALL abort the operation, with no done pulse and p = 0.
REQ-021 The first start SHALL be accepted on the first rising edge at which rst_n=1 and start=1.

Structure
REQ-022 A shared package/header SHALL hold:
- State encodings: IDLE=2'b00, CALC=2'b01, DONE=2'b10.
- The counter width constant, clog2(NBITS+1).
REQ-023 Unused encoding 2'b11 SHALL transition to IDLE.
REQ-024 The add SHALL use one instance of the existing ripple adder addergen_st, with:
- NBITS passed through
- cin tied to 0
- cout feeding the shift
No behavioural "+" is allowed on the datapath.
REQ-025 Control (FSM and counter) and datapath registers SHALL live in this module; no other sub-modules.

Verification (NBITS=16)
REQ-026 Basic product: a=3, b=5, start for 1 cycle -> busy for 16 cycles, then done for 1 cycle, p=32'h0000000F.
REQ-027 Maximum operands: a=16'hFFFF, b=16'hFFFF -> p=32'hFFFE0001 at done; 16'h8000*16'h0002 -> p=32'h00010000.
REQ-028 Zero operands: a=0, b=16'h1234 -> p=0; a=16'h1234, b=0 -> p=0; same latency as REQ-026.
REQ-029 Ignored start and operand changes: start pulsed again mid-CALC with a and b changed -> exactly one done and the original product; p unchanged until that done.
REQ-030 Reset mid-operation: rst_n low at the 8th CALC cycle -> busy, done and p go 0 immediately; a start after release with a=7, b=9 -> p=32'h0000003F.
REQ-031 Back-to-back: start held high with a=2, b=3 -> done every 18 cycles, p=6 each time.
